// File: rtl/spi_master_nss_pkg.sv
// Shared state encoding, SPI mode constants and mode-field helpers
// for the parametrised multi-slave SPI master.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_XFER  = 3'd2,
      ST_GAP   = 3'd3,
      ST_TAIL  = 3'd4
   } state_e;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   localparam int CPOL_IDX = 1;
   localparam int CPHA_IDX = 0;

   // CPHA=0 captures MISO on the leading SCLK edge, CPHA=1 on the trailing one.
   function automatic logic samples_on_lead(input logic [1:0] mode);
      return ~mode[CPHA_IDX];
   endfunction

endpackage

// File: rtl/spi_master_nss_if.sv
// System-side word handshake between the sensor/log controller and the SPI master.
interface spi_master_nss_if #(
   parameter int DATABITS = 8,
   parameter int SPI_SIZE = 2
);
   logic [1:0]          i_mode;
   logic [SPI_SIZE-1:0] i_ss_code;
   logic                i_tx_dv;
   logic [DATABITS-1:0] i_tx_byte;
   logic                i_tx_last;
   logic                o_tx_ready;
   logic                o_rx_dv;
   logic [DATABITS-1:0] o_rx_byte;
   logic                o_busy;
   logic                o_err;

   modport slave (
      input  i_mode, i_ss_code, i_tx_dv, i_tx_byte, i_tx_last,
      output o_tx_ready, o_rx_dv, o_rx_byte, o_busy, o_err
   );

   modport master (
      output i_mode, i_ss_code, i_tx_dv, i_tx_byte, i_tx_last,
      input  o_tx_ready, o_rx_dv, o_rx_byte, o_busy, o_err
   );
endinterface

// File: rtl/spi_master_nss_clk_gen.sv
// SCLK generator: half-bit counter producing lead/trail edge strobes one cycle
// ahead of the SCLK toggle, and a done strobe on the final edge of a word.
module spi_clk_gen #(
   parameter int DATABITS = 8,
   parameter int CLK_DIV  = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic cpol_i,
   output logic sclk_o,
   output logic lead_o,
   output logic trail_o,
   output logic done_o
);

   localparam int HALF = CLK_DIV / 2;
   localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int EW   = $clog2(2 * DATABITS);

   logic [HW-1:0] half_q, half_d;
   logic [EW-1:0] edg_q, edg_d;
   logic          ph_q, ph_d;
   logic          tick;

   assign tick = en_i && (half_q == HW'(HALF - 1));

   always_comb begin
      half_d = half_q;
      edg_d  = edg_q;
      ph_d   = ph_q;
      if (!en_i) begin
         half_d = '0;
         edg_d  = '0;
         ph_d   = 1'b0;
      end else if (tick) begin
         half_d = '0;
         edg_d  = edg_q + EW'(1);
         ph_d   = ~ph_q;
      end else begin
         half_d = half_q + HW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         half_q <= '0;
         edg_q  <= '0;
         ph_q   <= 1'b0;
      end else begin
         half_q <= half_d;
         edg_q  <= edg_d;
         ph_q   <= ph_d;
      end
   end

   // Even edge indices leave the idle level, odd ones return to it.
   assign lead_o  = tick && !edg_q[0];
   assign trail_o = tick &&  edg_q[0];
   assign done_o  = tick && (edg_q == EW'(2 * DATABITS - 1));
   assign sclk_o  = cpol_i ^ ph_q;

endmodule

// File: rtl/spi_master_nss.sv
// Multi-slave SPI master with runtime mode select and CS-held word bursts:
// FSM, MOSI/MISO shift registers and chip-select decode.
module spi_master_nss
   import spi_pkg::*;
#(
   parameter int DATABITS    = 8,
   parameter int NUM_SS      = 4,
   parameter int SPI_SIZE    = 2,
   parameter int CLK_DIV     = 8,
   parameter int RST_MODE    = 3,
   parameter int GAP_TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst,
   spi_master_nss_if.slave     bus,
   output logic                o_spi_clk,
   output logic                o_spi_mosi,
   input  logic                i_spi_miso,
   output logic [NUM_SS-1:0]   o_spi_cs_n
);

   localparam int HALF  = CLK_DIV / 2;
   localparam int CNT_W = $clog2(GAP_TIMEOUT + HALF + 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          mode_q, mode_d;
   logic [SPI_SIZE-1:0] ss_q, ss_d;
   logic                last_q, last_d;
   logic                mosi_q, mosi_d;
   logic [DATABITS-1:0] rx_byte_q, rx_byte_d;
   logic                rx_dv_q, rx_dv_d;
   logic                err_q, err_d;
   logic [DATABITS-1:0] tx_q, tx_d;
   logic [DATABITS-1:0] rx_q, rx_d;
   logic [DATABITS-1:0] rx_sh;
   logic                load;
   logic                code_ok;
   logic                clk_en, lead, trail, done;

   spi_clk_gen #(
      .DATABITS (DATABITS),
      .CLK_DIV  (CLK_DIV)
   ) u_clk_gen (
      .clk     (clk),
      .rst     (rst),
      .en_i    (clk_en),
      .cpol_i  (mode_q[CPOL_IDX]),
      .sclk_o  (o_spi_clk),
      .lead_o  (lead),
      .trail_o (trail),
      .done_o  (done)
   );

   assign clk_en  = (state_q == ST_XFER);
   assign code_ok = (32'(bus.i_ss_code) < NUM_SS);
   assign rx_sh   = (rx_q << 1) | DATABITS'(i_spi_miso);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      ss_d      = ss_q;
      last_d    = last_q;
      mosi_d    = mosi_q;
      rx_byte_d = rx_byte_q;
      rx_dv_d   = 1'b0;
      err_d     = 1'b0;
      tx_d      = tx_q;
      rx_d      = rx_q;
      load      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.i_tx_dv) begin
               if (code_ok) begin
                  mode_d = bus.i_mode;
                  ss_d   = bus.i_ss_code;
                  load   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_SETUP: begin
            if (cnt_q == CNT_W'(HALF - 1)) begin
               cnt_d   = '0;
               state_d = ST_XFER;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_XFER: begin
            if (samples_on_lead(mode_q)) begin
               if (lead) rx_d = rx_sh;
               if (trail) begin
                  tx_d   = tx_q << 1;
                  mosi_d = tx_q[DATABITS-2];
               end
            end else begin
               if (lead) begin
                  mosi_d = tx_q[DATABITS-1];
                  tx_d   = tx_q << 1;
               end
               if (trail) rx_d = rx_sh;
            end
            if (done) begin
               rx_byte_d = rx_d;
               rx_dv_d   = 1'b1;
               cnt_d     = '0;
               state_d   = last_q ? ST_TAIL : ST_GAP;
            end
         end
         ST_GAP: begin
            // Mode and slave stay locked for the whole burst.
            if (bus.i_tx_dv) begin
               load = 1'b1;
            end else if (cnt_q == CNT_W'(GAP_TIMEOUT - 1)) begin
               cnt_d   = '0;
               state_d = ST_TAIL;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_TAIL: begin
            if (cnt_q == CNT_W'(HALF - 1)) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         tx_d    = bus.i_tx_byte;
         last_d  = bus.i_tx_last;
         cnt_d   = '0;
         state_d = ST_SETUP;
         if (samples_on_lead(mode_d)) mosi_d = bus.i_tx_byte[DATABITS-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         mode_q    <= 2'(RST_MODE);
         ss_q      <= '0;
         last_q    <= 1'b0;
         mosi_q    <= 1'b0;
         rx_byte_q <= '0;
         rx_dv_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mode_q    <= mode_d;
         ss_q      <= ss_d;
         last_q    <= last_d;
         mosi_q    <= mosi_d;
         rx_byte_q <= rx_byte_d;
         rx_dv_q   <= rx_dv_d;
         err_q     <= err_d;
      end
   end

   // Shift registers carry data only; their contents are reloaded per word.
   always_ff @(posedge clk) begin
      tx_q <= tx_d;
      rx_q <= rx_d;
   end

   always_comb begin
      o_spi_cs_n = '1;
      for (int k = 0; k < NUM_SS; k++) begin
         if ((state_q != ST_IDLE) && (ss_q == SPI_SIZE'(k))) o_spi_cs_n[k] = 1'b0;
      end
   end

   assign o_spi_mosi     = mosi_q;
   assign bus.o_tx_ready = (state_q == ST_IDLE) || (state_q == ST_GAP);
   assign bus.o_busy     = (state_q != ST_IDLE);
   assign bus.o_rx_dv    = rx_dv_q;
   assign bus.o_rx_byte  = rx_byte_q;
   assign bus.o_err      = err_q;

endmodule

// File: tb/tb_spi_master_nss.sv
// Directed bench for spi_master_nss: single words in all modes, a CS-held burst,
// gap timeout, invalid slave code and mid-transfer reset.
module tb_spi_master_nss;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       sclk, mosi, miso;
   logic [3:0] cs_n;
   logic       sclk2, mosi2;
   logic [2:0] cs_n2;

   spi_master_nss_if #(.DATABITS(8), .SPI_SIZE(2)) bus  ();
   spi_master_nss_if #(.DATABITS(8), .SPI_SIZE(2)) bus2 ();

   spi_master_nss #(
      .DATABITS(8), .NUM_SS(4), .SPI_SIZE(2), .CLK_DIV(8), .RST_MODE(3), .GAP_TIMEOUT(64)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .o_spi_clk(sclk), .o_spi_mosi(mosi), .i_spi_miso(miso), .o_spi_cs_n(cs_n)
   );

   spi_master_nss #(
      .DATABITS(8), .NUM_SS(3), .SPI_SIZE(2), .CLK_DIV(8), .RST_MODE(3), .GAP_TIMEOUT(64)
   ) dut2 (
      .clk(clk), .rst(rst), .bus(bus2),
      .o_spi_clk(sclk2), .o_spi_mosi(mosi2), .i_spi_miso(1'b0), .o_spi_cs_n(cs_n2)
   );

   // Slave model: behavioural SPI slave evaluated between clock edges.
   logic [1:0] slv_mode = 2'b11;
   logic [7:0] slv_word = 8'h00;
   logic [7:0] slv_sh   = 8'h00;
   logic [7:0] slv_rx   = 8'h00;
   logic       slv_act  = 1'b0;
   logic       slv_prev = 1'b1;
   logic       slv_lead;
   logic       miso_m   = 1'b0;
   logic       loop_en  = 1'b0;
   logic       burst_mon = 1'b0;
   int         rx_cnt = 0, err_cnt = 0, cs_gap_hi = 0;

   assign miso = loop_en ? mosi : miso_m;

   always @(negedge clk) begin
      if (cs_n == 4'hF) begin
         slv_act = 1'b0;
      end else if (!slv_act) begin
         slv_act  = 1'b1;
         slv_sh   = slv_word;
         slv_prev = sclk;
         if (!slv_mode[0]) miso_m = slv_sh[7];
      end else if (sclk != slv_prev) begin
         slv_lead = (sclk != slv_mode[1]);
         if (slv_lead != slv_mode[0]) slv_rx = {slv_rx[6:0], mosi};
         if (slv_mode[0] && slv_lead) begin
            miso_m = slv_sh[7];
            slv_sh = {slv_sh[6:0], 1'b0};
         end
         if (!slv_mode[0] && !slv_lead) begin
            slv_sh = {slv_sh[6:0], 1'b0};
            miso_m = slv_sh[7];
         end
         slv_prev = sclk;
      end
      if (bus.o_rx_dv) rx_cnt++;
      if (bus2.o_err) err_cnt++;
      if (burst_mon && cs_n[2]) cs_gap_hi++;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [1:0] m, input logic [1:0] c, input logic [7:0] b,
                       input logic l);
      bus.i_mode    = m;
      bus.i_ss_code = c;
      bus.i_tx_byte = b;
      bus.i_tx_last = l;
      bus.i_tx_dv   = 1'b1;
      @(negedge clk);
      bus.i_tx_dv   = 1'b0;
   endtask

   // Called one cycle after the accepted strobe; returns cycles since that strobe.
   task automatic wait_rx(output int lat);
      lat = 1;
      while (!bus.o_rx_dv && lat < 300) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic wait_ready(inout int lat);
      while (!bus.o_tx_ready && lat < 400) begin
         @(negedge clk);
         lat++;
      end
   endtask

   typedef struct {
      logic [1:0] mode;
      logic [1:0] code;
      logic [7:0] tx;
      logic       loop;
      logic [7:0] slv;
      logic [7:0] exp_rx;
      logic [3:0] exp_cs;
   } vec_t;

   vec_t vecs[4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int rc0;
      int ec0;

      vecs[0] = '{2'd3, 2'd1, 8'hA5, 1'b0, 8'h3C, 8'h3C, 4'b1101};
      vecs[1] = '{2'd0, 2'd0, 8'h81, 1'b1, 8'h00, 8'h81, 4'b1110};
      vecs[2] = '{2'd1, 2'd3, 8'h81, 1'b1, 8'h00, 8'h81, 4'b0111};
      vecs[3] = '{2'd2, 2'd2, 8'h81, 1'b1, 8'h00, 8'h81, 4'b1011};

      bus.i_mode = 2'd0;  bus.i_ss_code = 2'd0;  bus.i_tx_dv = 1'b0;
      bus.i_tx_byte = 8'h00;  bus.i_tx_last = 1'b0;
      bus2.i_mode = 2'd0; bus2.i_ss_code = 2'd0; bus2.i_tx_dv = 1'b0;
      bus2.i_tx_byte = 8'h00; bus2.i_tx_last = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_ready",   bus.o_tx_ready, 1);
      chk("rst_rx_dv",   bus.o_rx_dv, 0);
      chk("rst_rx_byte", bus.o_rx_byte, 0);
      chk("rst_busy",    bus.o_busy, 0);
      chk("rst_err",     bus.o_err, 0);
      chk("rst_cs_n",    cs_n, 4'hF);
      chk("rst_mosi",    mosi, 0);
      chk("rst_sclk",    sclk, 1);

      for (int i = 0; i < 4; i++) begin
         slv_mode = vecs[i].mode;
         slv_word = vecs[i].slv;
         loop_en  = vecs[i].loop;
         send(vecs[i].mode, vecs[i].code, vecs[i].tx, 1'b1);
         chk($sformatf("v%0d_cs_n", i),   cs_n, vecs[i].exp_cs);
         chk($sformatf("v%0d_sclk_setup", i), sclk, vecs[i].mode[1]);
         chk($sformatf("v%0d_busy", i),   bus.o_busy, 1);
         chk($sformatf("v%0d_ready", i),  bus.o_tx_ready, 0);
         if (!vecs[i].mode[0]) chk($sformatf("v%0d_mosi_msb", i), mosi, vecs[i].tx[7]);
         wait_rx(lat);
         chk($sformatf("v%0d_rx_lat", i),  lat, 69);
         chk($sformatf("v%0d_rx_byte", i), bus.o_rx_byte, vecs[i].exp_rx);
         wait_ready(lat);
         chk($sformatf("v%0d_ready_lat", i), lat, 73);
         chk($sformatf("v%0d_cs_release", i), cs_n, 4'hF);
         chk($sformatf("v%0d_sclk_idle", i), sclk, vecs[i].mode[1]);
         chk($sformatf("v%0d_mosi_seen", i), slv_rx, vecs[i].tx);
         repeat (3) @(negedge clk);
      end

      // Three-word burst on slave 2; later words carry different mode/code.
      slv_mode = 2'd0; loop_en = 1'b1; rc0 = rx_cnt; cs_gap_hi = 0;
      send(2'd0, 2'd2, 8'h11, 1'b0);
      burst_mon = 1'b1;
      chk("burst_cs0", cs_n, 4'b1011);
      wait_rx(lat);
      chk("burst_lat0", lat, 69);
      chk("burst_rx0", bus.o_rx_byte, 8'h11);
      chk("burst_gap_ready", bus.o_tx_ready, 1);
      send(2'd3, 2'd0, 8'h25, 1'b0);
      chk("burst_cs1", cs_n, 4'b1011);
      chk("burst_sclk1", sclk, 0);
      wait_rx(lat);
      chk("burst_rx1", bus.o_rx_byte, 8'h25);
      send(2'd1, 2'd1, 8'h82, 1'b1);
      wait_rx(lat);
      chk("burst_lat2", lat, 69);
      chk("burst_rx2", bus.o_rx_byte, 8'h82);
      wait_ready(lat);
      burst_mon = 1'b0;
      chk("burst_ready_lat", lat, 73);
      chk("burst_cs_release", cs_n, 4'hF);
      chk("burst_cs_held", cs_gap_hi, 0);
      chk("burst_rx_pulses", rx_cnt - rc0, 3);
      repeat (3) @(negedge clk);

      // Non-last word followed by silence: gap timeout releases CS.
      slv_mode = 2'd1;
      send(2'd1, 2'd3, 8'h5A, 1'b0);
      wait_rx(lat);
      chk("gto_rx", bus.o_rx_byte, 8'h5A);
      lat = 0;
      while (bus.o_busy && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("gto_release_lat", lat, 68);
      chk("gto_cs", cs_n, 4'hF);
      slv_mode = 2'd2;
      send(2'd2, 2'd0, 8'h3C, 1'b1);
      chk("fresh_cs", cs_n, 4'b1110);
      chk("fresh_sclk", sclk, 1);
      wait_rx(lat);
      chk("fresh_lat", lat, 69);
      chk("fresh_rx", bus.o_rx_byte, 8'h3C);
      wait_ready(lat);
      repeat (3) @(negedge clk);

      // Out-of-range slave code on the three-slave instance.
      ec0 = err_cnt;
      bus2.i_ss_code = 2'd3; bus2.i_tx_byte = 8'hFF; bus2.i_tx_last = 1'b1;
      bus2.i_tx_dv = 1'b1;
      @(negedge clk);
      bus2.i_tx_dv = 1'b0;
      chk("err_pulse", bus2.o_err, 1);
      chk("err_cs", cs_n2, 3'b111);
      chk("err_ready", bus2.o_tx_ready, 1);
      chk("err_busy", bus2.o_busy, 0);
      @(negedge clk);
      chk("err_clear", bus2.o_err, 0);
      repeat (4) @(negedge clk);
      chk("err_count", err_cnt - ec0, 1);
      chk("err_cs_after", cs_n2, 3'b111);

      // Reset on the 7th SCLK edge of a mode-0 transfer.
      slv_mode = 2'd0; rc0 = rx_cnt;
      send(2'd0, 2'd1, 8'hF0, 1'b1);
      repeat (31) @(negedge clk);
      chk("abort_busy", bus.o_busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_cs", cs_n, 4'hF);
      chk("abort_sclk", sclk, 1);
      chk("abort_busy_after", bus.o_busy, 0);
      chk("abort_ready", bus.o_tx_ready, 1);
      repeat (80) @(negedge clk);
      chk("abort_no_rx", rx_cnt - rc0, 0);
      slv_mode = 2'd3;
      send(2'd3, 2'd0, 8'hC3, 1'b1);
      chk("post_cs", cs_n, 4'b1110);
      wait_rx(lat);
      chk("post_lat", lat, 69);
      chk("post_rx", bus.o_rx_byte, 8'hC3);
      wait_ready(lat);
      chk("post_ready_lat", lat, 73);
      chk("post_mosi_seen", slv_rx, 8'hC3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
